peach_mem_arbiter: RTL and testbench

Shares the single-port program/data RAM of the peach32 multi-cycle core between the instruction-fetch requester and the load/store requester. After reset it first runs a boot sequence that copies the program ROM into RAM word by word, then raises `boot_done` and starts arbitrating. It sits between the core's FETCH/LOAD/STORE states and the RAM macro, and replaces the core's direct combinational ROM read.

---
 rtl/peach_pkg.sv | 17 +
 rtl/peach_rr_arb2.sv | 44 ++++
 rtl/peach_mem_arbiter.sv | 136 +++++++++++++
 tb/tb_peach_mem_arbiter.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/peach_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// peach_pkg : shared types and widths for the peach32 memory arbiter
// Revision  : 1.0
// ---------------------------------------------------------------------------
package peach_pkg;

  typedef enum logic [0:0] {
    ARB_BOOT = 1'b0,
    ARB_RUN  = 1'b1
  } arb_state_t;

  localparam int MEM_DATA_W = 32;
  localparam int MEM_BE_W   = 4;

endpackage
`default_nettype wire

// File: rtl/peach_rr_arb2.sv
`default_nettype none
// ---------------------------------------------------------------------------
// peach_rr_arb2 : two-requester round-robin arbiter (req[1] = data, req[0] = fetch)
// Revision      : 1.0
// ---------------------------------------------------------------------------
module peach_rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] gnt
);

  logic last_d_q;
  logic last_d_d;

  // On contention data wins unless data held the previous grant
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last_d_q ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  always_comb begin
    last_d_d = last_d_q;
    if (update && (gnt != 2'b00)) begin
      last_d_d = gnt[1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_d_q <= 1'b0;
    end else begin
      last_d_q <= last_d_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/peach_mem_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// peach_mem_arbiter : ROM-to-RAM boot copy, then fetch/data sharing of one RAM port
// Revision          : 1.0
// ---------------------------------------------------------------------------
module peach_mem_arbiter
  import peach_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int BOOT_WORDS = 4096
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  boot_done,
  input  logic                  if_req,
  input  logic [31:0]           if_addr,
  output logic                  if_gnt,
  output logic                  if_rvalid,
  output logic [MEM_DATA_W-1:0] if_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [31:0]           d_addr,
  input  logic [MEM_DATA_W-1:0] d_wdata,
  input  logic [MEM_BE_W-1:0]   d_be,
  output logic                  d_gnt,
  output logic                  d_rvalid,
  output logic [MEM_DATA_W-1:0] d_rdata,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [MEM_DATA_W-1:0] rom_data,
  output logic                  ram_en,
  output logic                  ram_we,
  output logic [MEM_BE_W-1:0]   ram_be,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [MEM_DATA_W-1:0] ram_wdata,
  input  logic [MEM_DATA_W-1:0] ram_rdata
);

  localparam int CNT_W = ADDR_WIDTH + 1;
  localparam logic [CNT_W-1:0] BOOT_N    = CNT_W'(BOOT_WORDS);
  localparam logic [CNT_W-1:0] BOOT_LAST = CNT_W'((BOOT_WORDS == 0) ? 0 : BOOT_WORDS - 1);

  arb_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             boot_done_q, boot_done_d;
  logic             if_rvalid_q, if_rvalid_d;
  logic             d_rvalid_q, d_rvalid_d;

  logic             run;
  logic             boot_wr;
  logic [1:0]       arb_gnt;

  assign run     = (state_q == ARB_RUN);
  assign boot_wr = (state_q == ARB_BOOT) && (cnt_q < BOOT_N);

  peach_rr_arb2 u_rr_arb2 (
    .clk    (clk),
    .reset  (reset),
    .req    ({d_req & run, if_req & run}),
    .update (run),
    .gnt    (arb_gnt)
  );

  assign d_gnt  = arb_gnt[1];
  assign if_gnt = arb_gnt[0];

  // Byte-address offset and bits beyond the RAM depth are deliberately dropped
  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_addr[31:ADDR_WIDTH+2], if_addr[1:0],
                              d_addr[31:ADDR_WIDTH+2], d_addr[1:0]};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    boot_done_d = boot_done_q;
    if (state_q == ARB_BOOT) begin
      if (boot_wr) begin
        cnt_d = cnt_q + 1'b1;
      end
      if (cnt_q >= BOOT_LAST) begin
        state_d     = ARB_RUN;
        boot_done_d = 1'b1;
      end
    end
    if_rvalid_d = if_gnt;
    d_rvalid_d  = d_gnt & ~d_we;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ARB_BOOT;
      cnt_q       <= '0;
      boot_done_q <= 1'b0;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      boot_done_q <= boot_done_d;
      if_rvalid_q <= if_rvalid_d;
      d_rvalid_q  <= d_rvalid_d;
    end
  end

  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_be    = '0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (boot_wr) begin
      ram_en    = 1'b1;
      ram_we    = 1'b1;
      ram_be    = '1;
      ram_addr  = cnt_q[ADDR_WIDTH-1:0];
      ram_wdata = rom_data;
    end else if (d_gnt) begin
      ram_en    = 1'b1;
      ram_we    = d_we;
      ram_be    = d_we ? d_be : '0;
      ram_addr  = d_addr[ADDR_WIDTH+1:2];
      ram_wdata = d_we ? d_wdata : '0;
    end else if (if_gnt) begin
      ram_en   = 1'b1;
      ram_addr = if_addr[ADDR_WIDTH+1:2];
    end
  end

  assign rom_addr  = cnt_q[ADDR_WIDTH-1:0];
  assign boot_done = boot_done_q;
  assign if_rvalid = if_rvalid_q;
  assign d_rvalid  = d_rvalid_q;
  assign if_rdata  = ram_rdata;
  assign d_rdata   = ram_rdata;

endmodule
`default_nettype wire

// File: tb/tb_peach_mem_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_peach_mem_arbiter : directed bench with ROM/RAM models, BOOT_WORDS = 8
// Revision             : 1.0
// ---------------------------------------------------------------------------
module tb_peach_mem_arbiter;

  localparam int AW = 12;
  localparam int BW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          boot_done;
  logic          if_req;
  logic [31:0]   if_addr;
  logic          if_gnt;
  logic          if_rvalid;
  logic [31:0]   if_rdata;
  logic          d_req;
  logic          d_we;
  logic [31:0]   d_addr;
  logic [31:0]   d_wdata;
  logic [3:0]    d_be;
  logic          d_gnt;
  logic          d_rvalid;
  logic [31:0]   d_rdata;
  logic [AW-1:0] rom_addr;
  logic [31:0]   rom_data;
  logic          ram_en;
  logic          ram_we;
  logic [3:0]    ram_be;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_wdata;
  logic [31:0]   ram_rdata;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  peach_mem_arbiter #(.ADDR_WIDTH(AW), .BOOT_WORDS(BW)) dut (
    .clk(clk), .reset(reset), .boot_done(boot_done),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .ram_en(ram_en), .ram_we(ram_we), .ram_be(ram_be), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  // Combinational ROM and 1-cycle-latency byte-writable RAM
  assign rom_data = 32'hA000_0000 + {20'd0, rom_addr};

  logic [31:0] mem [0:(1<<AW)-1];
  initial for (int i = 0; i < (1<<AW); i++) mem[i] = 32'h0;

  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) begin
        for (int b = 0; b < 4; b++)
          if (ram_be[b]) mem[ram_addr][b*8 +: 8] <= ram_wdata[b*8 +: 8];
      end else begin
        ram_rdata <= mem[ram_addr];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  initial begin
    reset = 1'b1; if_req = 0; if_addr = 0; d_req = 0; d_we = 0;
    d_addr = 0; d_wdata = 0; d_be = 0;
    #2;
    chk("rst_boot_done", {31'd0, boot_done}, 32'd0);
    chk("rst_if_rvalid", {31'd0, if_rvalid}, 32'd0);
    chk("rst_d_rvalid",  {31'd0, d_rvalid},  32'd0);
    chk("rst_ram_we",    {31'd0, ram_we},    32'd1);
    chk("rst_rom_addr",  {20'd0, rom_addr},  32'd0);

    // Boot copy with both requesters pushing
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < BW; k++) begin
      if_req = 1; d_req = 1; if_addr = 32'h0; d_addr = 32'h0;
      #1;
      chk("boot_addr",  {20'd0, ram_addr}, k);
      chk("boot_wdata", ram_wdata, 32'hA000_0000 + k);
      chk("boot_we_en", {30'd0, ram_en, ram_we}, 32'd3);
      chk("boot_be",    {28'd0, ram_be}, 32'hF);
      chk("boot_gnt",   {30'd0, if_gnt, d_gnt}, 32'd0);
      chk("boot_done_lo", {31'd0, boot_done}, 32'd0);
      @(negedge clk);
    end
    if_req = 0; d_req = 0;
    #1;
    chk("boot_done_hi", {31'd0, boot_done}, 32'd1);
    chk("idle_ram_en",  {31'd0, ram_en}, 32'd0);
    chk("mem_word7",    mem[7], 32'hA000_0007);

    // Fetch read of word 5
    @(negedge clk);
    if_req = 1; if_addr = 32'h0000_0014;
    #1;
    chk("f_gnt",  {30'd0, if_gnt, d_gnt}, 32'd2);
    chk("f_addr", {20'd0, ram_addr}, 32'd5);
    chk("f_we",   {31'd0, ram_we}, 32'd0);
    @(negedge clk);
    if_req = 0;
    chk("f_rvalid", {30'd0, if_rvalid, d_rvalid}, 32'd2);
    chk("f_rdata",  if_rdata, 32'hA000_0005);
    @(negedge clk);
    chk("f_rvalid_pulse", {31'd0, if_rvalid}, 32'd0);

    // Partial data write then read-back
    d_req = 1; d_we = 1; d_addr = 32'h10; d_wdata = 32'hDEAD_BEEF; d_be = 4'b0011;
    #1;
    chk("w_gnt",  {30'd0, if_gnt, d_gnt}, 32'd1);
    chk("w_port", {ram_we, ram_be, 7'd0, 8'd0, ram_addr}, {1'b1, 4'b0011, 15'd0, 12'd4});
    chk("w_wdata", ram_wdata, 32'hDEAD_BEEF);
    @(negedge clk);
    chk("w_no_rvalid", {31'd0, d_rvalid}, 32'd0);
    d_we = 0;
    #1;
    chk("r_gnt", {31'd0, d_gnt}, 32'd1);
    @(negedge clk);
    d_req = 0;
    chk("r_rvalid", {31'd0, d_rvalid}, 32'd1);
    chk("r_rdata",  d_rdata, 32'hA000_BEEF);
    @(negedge clk);
    chk("r_rvalid_pulse", {31'd0, d_rvalid}, 32'd0);

    // Byte-enable zero write consumes the slot but leaves the word intact
    d_req = 1; d_we = 1; d_addr = 32'h10; d_wdata = 32'h1234_5678; d_be = 4'b0000;
    #1;
    chk("be0_gnt", {31'd0, d_gnt}, 32'd1);
    @(negedge clk);
    d_req = 0; d_we = 0;
    chk("be0_mem", mem[4], 32'hA000_BEEF);

    // Fetch only, so the round-robin pointer points at data
    if_req = 1; if_addr = 32'h0;
    @(negedge clk);
    chk("pre_rdata", if_rdata, 32'hA000_0000);

    // Contention: d, if, d, if
    if_req = 1; if_addr = 32'h8; d_req = 1; d_we = 0; d_addr = 32'hC;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("cont_gnt", {30'd0, if_gnt, d_gnt}, (i % 2 == 0) ? 32'd1 : 32'd2);
      @(negedge clk);
      chk("cont_rvalid", {30'd0, if_rvalid, d_rvalid}, (i % 2 == 0) ? 32'd1 : 32'd2);
      chk("cont_rdata", ram_rdata, (i % 2 == 0) ? 32'hA000_0003 : 32'hA000_0002);
    end
    if_req = 0; d_req = 0;

    // Address wrap modulo RAM size
    @(negedge clk);
    d_req = 1; d_addr = 32'h0000_4004;
    #1;
    chk("wrap_addr", {20'd0, ram_addr}, 32'd1);
    @(negedge clk);
    d_req = 0;
    chk("wrap_rdata", d_rdata, 32'hA000_0001);

    // Reset in the cycle of a read grant
    @(negedge clk);
    if_req = 1; if_addr = 32'h18;
    #1;
    chk("rr_gnt", {31'd0, if_gnt}, 32'd1);
    #1;
    reset = 1; if_req = 0;
    #1;
    chk("rr_boot_done", {31'd0, boot_done}, 32'd0);
    chk("rr_ram_addr",  {20'd0, ram_addr}, 32'd0);
    @(negedge clk);
    chk("rr_no_rvalid", {30'd0, if_rvalid, d_rvalid}, 32'd0);
    reset = 0;
    #1;
    chk("rr_restart", {ram_en, ram_we, 18'd0, ram_addr}, 32'hC000_0000);
    for (int k = 0; k < BW; k++) @(negedge clk);
    chk("rr_boot_done_hi", {31'd0, boot_done}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
